// File: rtl/adder_ctrl_pkg.sv
// Shared types and helpers for the shared five-bit adder controller.
// Holds the limb width, FSM encoding and the round-robin pick function.
package adder_ctrl_pkg;

    localparam int LIMB_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // First requester at or after ptr (cyclic over n <= 8 requesters).
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int off = 0; off < 8; off++) begin
            idx = int'(ptr) + off;
            if (idx >= n) idx = idx - n;
            if (off < n && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_fa5.sv
// Five-bit ripple-carry adder shared by all requesters.
// Module name is kept from the existing datapath library.
module fiveBitFullAdder (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       cin,
    output logic [4:0] sum,
    output logic       cout
);

    logic [5:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 5; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[5];
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sharing of one five-bit adder, multi-limb sequencing.
// Optional subtract support is enabled with `define ADDER_SUB_EN.
module adder_share_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int LIMBS = 2,
    localparam int W     = LIMB_W * LIMBS,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
`ifdef ADDER_SUB_EN
    input  logic [NREQ-1:0]   sub_in,
`endif
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              done,
    output logic [IDW-1:0]    done_id,
    output logic [W-1:0]      sum,
    output logic              cout
);

    localparam int CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            carry_q, carry_d;
`ifdef ADDER_SUB_EN
    logic            sub_q, sub_d;
`endif

    logic [7:0]        req8;
    logic [IDW-1:0]    pick;
    logic              cin0;
    logic              last;
    logic [LIMB_W-1:0] a_limb, b_limb, fa_sum;
    logic              fa_cout;

    always_comb begin
        req8            = '0;
        req8[NREQ-1:0]  = req;
        pick = IDW'(rr_pick(req8, 3'(ptr_q), NREQ));
    end

    // Subtract is add of the inverted B with an initial carry of one.
`ifdef ADDER_SUB_EN
    assign cin0   = sub_in[pick];
    assign b_limb = b_q[int'(cnt_q)*LIMB_W +: LIMB_W] ^ {LIMB_W{sub_q}};
`else
    assign cin0   = 1'b0;
    assign b_limb = b_q[int'(cnt_q)*LIMB_W +: LIMB_W];
`endif
    assign a_limb = a_q[int'(cnt_q)*LIMB_W +: LIMB_W];
    assign last   = (cnt_q == CW'(LIMBS - 1));

    fiveBitFullAdder u_fa (
        .a    (a_limb),
        .b    (b_limb),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
`ifdef ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
`ifdef ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|req) state_d = ST_ADD;
            ST_ADD:  if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
`ifdef ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    win_d   = pick;
                    grant_d = NREQ'(1) << pick;
                    a_d     = a_in[int'(pick)*W +: W];
                    b_d     = b_in[int'(pick)*W +: W];
                    cnt_d   = '0;
                    acc_d   = '0;
                    carry_d = cin0;
`ifdef ADDER_SUB_EN
                    sub_d   = sub_in[pick];
`endif
                end
            end
            ST_ADD: begin
                acc_d[int'(cnt_q)*LIMB_W +: LIMB_W] = fa_sum;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                // Results are published only once the top limb is done.
                if (last) begin
                    sum_d  = acc_d;
                    cout_d = fa_cout;
                    cnt_d  = '0;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                if (win_q == IDW'(NREQ - 1)) ptr_d = '0;
                else ptr_d = win_q + IDW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        grant   = grant_q;
        done_id = win_q;
        sum     = sum_q;
        cout    = cout_q;
    end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Round-robin controller that shares one five-bit ripple adder among several requesters and sequences multi-limb additions through it. Each granted request adds two LIMBS×5-bit operands one limb per cycle, chaining the carry in a register. The result and carry-out are returned with a one-cycle done pulse tagged with the requester index. The block sits between the operand-producing units and the single adder datapath.

## Interface
- NREQ, 4: number of requesters (2..8).
- LIMBS, 2: five-bit limbs per operand; operand width W = 5*LIMBS.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; held high until its done.
- a_in  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- b_in  in  NREQ*W  operand B, same packing.
- sub_in  in  NREQ  per-requester subtract select (only with ADDER_SUB_EN).
- grant  out  NREQ  one-hot grant to the owner of the current operation.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when sum/cout are valid.
- done_id  out  clog2(NREQ)  index of the finished requester.
- sum  out  W  result; holds until the next done.
- cout  out  1  final carry-out; holds until the next done.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE with any req high:
  - Pick the winner by round-robin starting at ptr.
  - At the edge: latch the winner's A/B (and sub) into operand registers, set grant one-hot, set limb counter to 0, set the carry register to the initial carry-in, go to ADD.
  - IDLE with no req: stay.
- ADD:
  - Each cycle, feed limb[cnt] of A and B plus the carry register to the adder.
  - At the edge: store the adder sum into sum limb cnt, store the adder Cout into the carry register, increment cnt.
  - When cnt = LIMBS-1, go to DONE instead and register cout.
- DONE:
  - done=1, done_id = winner, grant still asserted.
  - At the edge: go to IDLE, clear grant, set ptr = (winner+1) mod NREQ.
- Arithmetic: modulo 2^W. cout is the carry out of the top limb.
- req changes after grant are ignored. Deasserting req mid-operation does not abort the operation. Operands are sampled only at grant.
- Simultaneous requests: the lowest index at or after ptr (cyclically) wins. All others wait.
- A requester that re-asserts immediately after its own done gets lowest priority in the next arbitration.

## Timing
- Reset values:
  - state=IDLE, ptr=0, cnt=0.
  - grant=0, busy=0, done=0, done_id=0.
  - sum=0, cout=0, carry register=0.
- Request seen in IDLE at cycle t:
  - grant and busy rise at t+1.
  - ADD occupies t+1..t+LIMBS.
  - done is high at t+LIMBS+1.
- Throughput: one operation per LIMBS+2 cycles. There is always one IDLE cycle between operations.
- sum and cout change only at the edge into DONE. They are stable from done until the next DONE.
- Reset during ADD or DONE: the operation is discarded, no done is emitted, and all outputs return to reset values on the next cycle.

## Configuration
- ADDER_SUB_EN:
  - Defined: the sub_in port exists and is latched at grant. When the latched sub is 1, B limbs are bit-inverted before the adder and the initial carry-in is 1, so sum = A − B mod 2^W and cout=1 means no borrow. When sub is 0, the block behaves as add.
  - Undefined: no sub_in port, initial carry-in is always 0, add only.

## Structure
- Shared package/header adder_ctrl_pkg holds:
  - LIMB_W=5.
  - FSM state encodings (IDLE, ADD, DONE).
  - The round-robin pick function used by both RTL and the bench model.
- One sub-module instance: fiveBitFullAdder, the existing five-bit ripple adder, driven by the selected limbs and the carry register.
- Round-robin arbitration logic is inline. No further sub-modules.

## Test plan
- Single add: req[1]=1, A=0x155, B=0x0AA, LIMBS=2
  - grant=0010 at t+1.
  - done at t+3 with sum=0x1FF, cout=0, done_id=1.
- Cross-limb carry: A=0x01F, B=0x001
  - sum=0x020, cout=0.
- Full overflow: A=0x3FF, B=0x001
  - sum=0x000, cout=1.
- Fairness: req=0101 held continuously from reset
  - done_id sequence is 0,2,0,2.
  - Each done is 4 cycles after the previous.
- Reset mid-operation: assert rst on the second ADD cycle
  - Next cycle: grant=0, busy=0, sum=0, done never pulses.
  - A new req afterwards completes normally with ptr=0.
- ADDER_SUB_EN: sub_in[3]=1, A=0x005, B=0x007
  - sum=0x3FE, cout=0.
- ADDER_SUB_EN: sub_in[3]=1, A=0x007, B=0x005
  - sum=0x002, cout=1.
